// File: rtl/weight_update_if.sv
// Handshake bundle for weight_update: sample in, weight-memory read/write ports, error out.
// master = the weight_update block, slave = sample source / weight memory / error sink.
interface weight_update_if #(
   parameter int W = 8,
   parameter int N = 4
);
   localparam int AW = $clog2(N + 1);

   logic                 s_stb;
   logic [(N+1)*W-1:0]   s_dat;
   logic                 s_rdy;
   logic                 raddr_stb;
   logic [AW-1:0]        raddr_dat;
   logic                 raddr_rdy;
   logic                 rdata_stb;
   logic [2*W-1:0]       rdata_dat;
   logic                 rdata_rdy;
   logic                 waddr_stb;
   logic [AW-1:0]        waddr_dat;
   logic                 waddr_rdy;
   logic                 wdata_stb;
   logic [2*W-1:0]       wdata_dat;
   logic                 wdata_rdy;
   logic                 m_stb;
   logic [2*W-1:0]       m_dat;
   logic                 m_rdy;

   modport master (
      input  s_stb, s_dat, raddr_rdy, rdata_stb, rdata_dat, waddr_rdy, wdata_rdy, m_rdy,
      output s_rdy, raddr_stb, raddr_dat, rdata_rdy, waddr_stb, waddr_dat,
             wdata_stb, wdata_dat, m_stb, m_dat
   );
   modport slave (
      output s_stb, s_dat, raddr_rdy, rdata_stb, rdata_dat, waddr_rdy, wdata_rdy, m_rdy,
      input  s_rdy, raddr_stb, raddr_dat, rdata_rdy, waddr_stb, waddr_dat,
             wdata_stb, wdata_dat, m_stb, m_dat
   );
endinterface

// File: rtl/weight_update.sv
// Backward-path weight updater: per index reads w_i, writes w_i - (delta*x_i)>>>R, emits e_i.
// WEIGHT_SATURATE_EN: clamp the updated weight on overflow instead of wrapping.
module weight_update #(
   parameter int W = 8,
   parameter int N = 4,
   parameter int R = 2
) (
   input  logic            clk,
   input  logic            rst,
   weight_update_if.master bus
);
   localparam int AW  = $clog2(N + 1);
   localparam int WW  = 2 * W;
   localparam int WW1 = 2 * W + 1;
   localparam int PW  = 3 * W;

   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, EMIT} state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [(N+1)*W-1:0] samp_q, samp_d;
   logic [WW-1:0]      wdata_q, wdata_d;
   logic [WW-1:0]      e_q, e_d;
   logic               s_rdy_q, s_rdy_d;
   logic               raddr_stb_q, raddr_stb_d;
   logic               rdata_rdy_q, rdata_rdy_d;
   logic               waddr_stb_q, waddr_stb_d;
   logic               wdata_stb_q, wdata_stb_d;
   logic               m_stb_q, m_stb_d;

   logic signed [W-1:0]  delta, x_i;
   logic signed [WW-1:0] w_old, q, w_new, e_new;

   assign delta = samp_q[N*W +: W];
   assign w_old = bus.rdata_dat;
   // Bias slot uses the constant -1 argument the forward path also applies.
   assign x_i   = (idx_q == AW'(N)) ? '1 : samp_q[int'(idx_q)*W +: W];
   assign q     = WW'(WW'(delta) * WW'(x_i)) >>> R;
   assign e_new = WW'((PW'(delta) * PW'(w_old)) >>> W);

`ifdef WEIGHT_SATURATE_EN
   logic signed [WW1-1:0] diff;
   assign diff = WW1'(w_old) - WW1'(q);
   always_comb begin
      w_new = diff[WW-1:0];
      if (diff[WW] != diff[WW-1])
         w_new = diff[WW] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
   end
`else
   assign w_new = w_old - q;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      samp_d      = samp_q;
      wdata_d     = wdata_q;
      e_d         = e_q;
      s_rdy_d     = s_rdy_q;
      raddr_stb_d = raddr_stb_q;
      rdata_rdy_d = rdata_rdy_q;
      waddr_stb_d = waddr_stb_q;
      wdata_stb_d = wdata_stb_q;
      m_stb_d     = m_stb_q;
      case (state_q)
         IDLE: if (bus.s_stb) begin
            samp_d      = bus.s_dat;
            idx_d       = '0;
            s_rdy_d     = 1'b0;
            raddr_stb_d = 1'b1;
            state_d     = READ;
         end
         READ: if (bus.raddr_rdy) begin
            raddr_stb_d = 1'b0;
            rdata_rdy_d = 1'b1;
            state_d     = WAIT;
         end
         WAIT: if (bus.rdata_stb) begin
            rdata_rdy_d = 1'b0;
            wdata_d     = w_new;
            e_d         = e_new;
            waddr_stb_d = 1'b1;
            wdata_stb_d = 1'b1;
            state_d     = WRITE;
         end
         WRITE: begin
            // Address and data channels retire independently; leave once both are done.
            if (bus.waddr_rdy) waddr_stb_d = 1'b0;
            if (bus.wdata_rdy) wdata_stb_d = 1'b0;
            if (!waddr_stb_d && !wdata_stb_d) begin
               if (idx_q != AW'(N)) begin
                  m_stb_d = 1'b1;
                  state_d = EMIT;
               end else begin
                  s_rdy_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         EMIT: if (bus.m_rdy) begin
            m_stb_d     = 1'b0;
            idx_d       = AW'(idx_q + 1'b1);
            raddr_stb_d = 1'b1;
            state_d     = READ;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         samp_q      <= '0;
         wdata_q     <= '0;
         e_q         <= '0;
         s_rdy_q     <= 1'b1;
         raddr_stb_q <= 1'b0;
         rdata_rdy_q <= 1'b0;
         waddr_stb_q <= 1'b0;
         wdata_stb_q <= 1'b0;
         m_stb_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         samp_q      <= samp_d;
         wdata_q     <= wdata_d;
         e_q         <= e_d;
         s_rdy_q     <= s_rdy_d;
         raddr_stb_q <= raddr_stb_d;
         rdata_rdy_q <= rdata_rdy_d;
         waddr_stb_q <= waddr_stb_d;
         wdata_stb_q <= wdata_stb_d;
         m_stb_q     <= m_stb_d;
      end
   end

   assign bus.s_rdy     = s_rdy_q;
   assign bus.raddr_stb = raddr_stb_q;
   assign bus.raddr_dat = idx_q;
   assign bus.rdata_rdy = rdata_rdy_q;
   assign bus.waddr_stb = waddr_stb_q;
   assign bus.waddr_dat = idx_q;
   assign bus.wdata_stb = wdata_stb_q;
   assign bus.wdata_dat = wdata_q;
   assign bus.m_stb     = m_stb_q;
   assign bus.m_dat     = e_q;
endmodule

// File: tb/tb_weight_update.sv
// Directed bench for weight_update with a small weight-memory model and handshake logs.
module tb_weight_update;
   localparam int W  = 8;
   localparam int N  = 4;
   localparam int R  = 2;
   localparam int AW = $clog2(N + 1);
   localparam int SW = (N + 1) * W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   weight_update_if #(.W(W), .N(N)) bus ();
   weight_update #(.W(W), .N(N), .R(R)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] mem      [0:N];
   logic [15:0] init_mem [0:N];
   logic [15:0] m_log    [0:15];
   logic [15:0] wr_log   [0:15];
   int          acc_cyc  [0:3];
   int          bias_c   [0:3];
   logic        load = 1'b0;
   logic        clr  = 1'b0;
   int          cyc = 0, m_cnt = 0, w_cnt = 0, acc_n = 0, bias_n = 0, viol = 0;
   logic        wa_v, wd_v;
   logic [AW-1:0] wa, wa_cur;
   logic [15:0] wd, wd_cur;
   logic        wa_fire, wd_fire, wa_done, wd_done;

   assign wa_fire = bus.waddr_stb && bus.waddr_rdy;
   assign wd_fire = bus.wdata_stb && bus.wdata_rdy;
   assign wa_done = wa_v || wa_fire;
   assign wd_done = wd_v || wd_fire;
   assign wa_cur  = wa_fire ? bus.waddr_dat : wa;
   assign wd_cur  = wd_fire ? bus.wdata_dat : wd;

   // Memory returns read data the cycle after the read index is accepted.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (load) mem <= init_mem;
      if (!rst) begin
         bus.rdata_stb <= 1'b0;
         wa_v          <= 1'b0;
         wd_v          <= 1'b0;
      end else begin
         if (bus.rdata_stb && bus.rdata_rdy) bus.rdata_stb <= 1'b0;
         if (bus.raddr_stb && bus.raddr_rdy) begin
            bus.rdata_stb <= 1'b1;
            bus.rdata_dat <= mem[bus.raddr_dat];
         end
         if (wa_done && wd_done) begin
            mem[wa_cur]        <= wd_cur;
            wr_log[w_cnt[3:0]] <= wd_cur;
            w_cnt              <= w_cnt + 1;
            wa_v               <= 1'b0;
            wd_v               <= 1'b0;
            if (wa_cur == AW'(N)) begin
               bias_c[bias_n[1:0]] <= cyc;
               bias_n              <= bias_n + 1;
            end
         end else begin
            if (wa_fire) begin wa_v <= 1'b1; wa <= bus.waddr_dat; end
            if (wd_fire) begin wd_v <= 1'b1; wd <= bus.wdata_dat; end
         end
         if (bus.m_stb && bus.m_rdy) begin
            m_log[m_cnt[3:0]] <= bus.m_dat;
            m_cnt             <= m_cnt + 1;
         end
         if (bus.s_stb && bus.s_rdy) begin
            acc_cyc[acc_n[1:0]] <= cyc;
            acc_n               <= acc_n + 1;
         end
         if (bus.raddr_stb && (bus.waddr_stb || bus.wdata_stb)) viol <= viol + 1;
      end
      if (clr) begin
         m_cnt <= 0; w_cnt <= 0; acc_n <= 0; bias_n <= 0; viol <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      n_cmp++;
      n_bad++;
      $error("FAIL %s: timed out waiting, got no event expected event", tag);
   endtask

   task automatic load_mem(input logic [15:0] w0, w1, w2, w3, w4);
      init_mem[0] = w0; init_mem[1] = w1; init_mem[2] = w2;
      init_mem[3] = w3; init_mem[4] = w4;
      load = 1'b1; clr = 1'b1;
      @(negedge clk);
      load = 1'b0; clr = 1'b0;
   endtask

   task automatic send(input logic [SW-1:0] d);
      int t = 0;
      @(negedge clk);
      while (!bus.s_rdy && t < 200) begin @(negedge clk); t++; end
      if (!bus.s_rdy) timeout("send");
      bus.s_dat = d;
      bus.s_stb = 1'b1;
      @(posedge clk);
      #1 bus.s_stb = 1'b0;
   endtask

   task automatic wait_done(input int nw);
      int t = 0;
      while (!(w_cnt >= nw && bus.s_rdy) && t < 500) begin @(negedge clk); t++; end
      if (!(w_cnt >= nw && bus.s_rdy)) timeout("sample_done");
   endtask

   initial begin
      int t;
      bus.s_stb = 1'b0; bus.s_dat = '0;
      bus.raddr_rdy = 1'b1; bus.waddr_rdy = 1'b1; bus.wdata_rdy = 1'b1; bus.m_rdy = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_s_rdy",     bus.s_rdy,     1);
      chk("rst_raddr_stb", bus.raddr_stb, 0);
      chk("rst_rdata_rdy", bus.rdata_rdy, 0);
      chk("rst_waddr_stb", bus.waddr_stb, 0);
      chk("rst_wdata_stb", bus.wdata_stb, 0);
      chk("rst_m_stb",     bus.m_stb,     0);
      chk("rst_m_dat",     bus.m_dat,     0);
      chk("rst_wdata_dat", bus.wdata_dat, 0);
      rst = 1'b1;

      // Basic update + bias, followed by a back-to-back second sample.
      load_mem(16'h0100, 16'hFF00, 16'h0040, 16'h1234, 16'h0010);
      send(40'h02_00_10_FC_04);
      chk("s_rdy_busy", bus.s_rdy, 0);
      bus.s_dat = 40'h04_00_00_00_00;
      bus.s_stb = 1'b1;
      t = 0;
      while (acc_n < 2 && t < 200) begin @(negedge clk); t++; end
      bus.s_stb = 1'b0;
      if (acc_n < 2) timeout("b2b_accept");
      wait_done(10);
      chk("wr0_basic",    wr_log[0], 16'h00FE);
      chk("wr1",          wr_log[1], 16'hFF02);
      chk("wr2",          wr_log[2], 16'h0038);
      chk("wr3",          wr_log[3], 16'h1234);
      chk("wr4_bias",     wr_log[4], 16'h0011);
      chk("e0_basic",     m_log[0],  16'h0002);
      chk("e1",           m_log[1],  16'hFFFE);
      chk("e2",           m_log[2],  16'h0000);
      chk("e3",           m_log[3],  16'h0024);
      chk("s2_e0",        m_log[4],  16'h0003);
      chk("s2_e1",        m_log[5],  16'hFFFC);
      chk("s2_e3",        m_log[7],  16'h0048);
      chk("s2_bias",      mem[4],    16'h0012);
      chk("m_pulses",     m_cnt,     8);
      chk("bias_latency", bias_c[0] - acc_cyc[0], 19);
      chk("b2b_gap",      acc_cyc[1] - bias_c[0], 1);
      chk("no_overlap",   viol,      0);

      // Overflow on the weight update.
      load_mem(16'h7FF0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      send(40'h7F_00_00_00_80);
      wait_done(5);
`ifdef WEIGHT_SATURATE_EN
      chk("sat_w0", mem[0], 16'h7FFF);
`else
      chk("wrap_w0", mem[0], 16'h8FD0);
`endif
      chk("sat_e0",   m_log[0], 16'h3F78);
      chk("sat_bias", mem[4],   16'h0020);

      // Backpressure on the read index and on the write data.
      load_mem(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      bus.raddr_rdy = 1'b0;
      bus.wdata_rdy = 1'b0;
      send(40'h02_00_00_00_04);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_raddr_stb", bus.raddr_stb, 1);
         chk("bp_raddr_dat", bus.raddr_dat, 0);
      end
      bus.raddr_rdy = 1'b1;
      t = 0;
      while (!(bus.wdata_stb && !bus.waddr_stb) && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) timeout("bp_waddr_done");
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         chk("bp_waddr_low",  bus.waddr_stb, 0);
         chk("bp_wdata_hold", bus.wdata_stb, 1);
         chk("bp_wdata_dat",  bus.wdata_dat, 16'h00FE);
         chk("bp_no_read",    bus.raddr_stb, 0);
      end
      bus.wdata_rdy = 1'b1;
      @(negedge clk);
      chk("bp_emit",      bus.m_stb,     1);
      chk("bp_emit_noread", bus.raddr_stb, 0);
      wait_done(5);
      chk("bp_w0",        mem[0], 16'h00FE);
      chk("bp_no_overlap", viol,  0);

      // Asynchronous reset while waiting for the index-2 read data.
      load_mem(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500);
      send(40'h02_04_04_04_04);
      t = 0;
      while (!(bus.rdata_rdy && bus.raddr_dat == AW'(2)) && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) timeout("rst_wait_idx2");
      #1 rst = 1'b0;
      #1;
      chk("ar_s_rdy",     bus.s_rdy,     1);
      chk("ar_rdata_rdy", bus.rdata_rdy, 0);
      chk("ar_raddr_stb", bus.raddr_stb, 0);
      chk("ar_waddr_stb", bus.waddr_stb, 0);
      chk("ar_wdata_stb", bus.wdata_stb, 0);
      chk("ar_m_stb",     bus.m_stb,     0);
      chk("ar_idx",       bus.raddr_dat, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("ar_w0", mem[0], 16'h00FE);
      chk("ar_w1", mem[1], 16'h01FE);
      chk("ar_w2", mem[2], 16'h0300);
      chk("ar_w3", mem[3], 16'h0400);
      chk("ar_w4", mem[4], 16'h0500);
      chk("ar_wcnt", w_cnt, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
